// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of one single-port on-chip RAM.
// Hold-limited round-robin grant, 0-cycle accept, 1-cycle read return with readdatavalid.
module onchip_memory_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    logic       r_owner;
    logic [3:0] r_hold_cnt;
    logic       r_rd_pend;
    logic       r_rd_id;

    logic       w_req0;
    logic       w_req1;
    logic       w_gnt_v;
    logic       w_gnt_id;
    logic       w_gnt_rd;

    // Handshake: a request is accepted in any cycle where it is held and waitrequest is low.
    always_comb begin
        w_req0   = m0_read | m0_write;
        w_req1   = m1_read | m1_write;
        w_gnt_v  = 1'b0;
        w_gnt_id = 1'b0;
        if (reset) begin
            w_gnt_v  = 1'b0;
        end else if (w_req0 && w_req1) begin
            w_gnt_v  = 1'b1;
            w_gnt_id = (r_hold_cnt < HOLD_LIMIT) ? r_owner : ~r_owner;
        end else if (w_req0) begin
            w_gnt_v  = 1'b1;
            w_gnt_id = 1'b0;
        end else if (w_req1) begin
            w_gnt_v  = 1'b1;
            w_gnt_id = 1'b1;
        end
        // Read+write together is treated as a write, so it never produces a response.
        w_gnt_rd = w_gnt_v & (w_gnt_id ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= 1'b0;
        end else begin
            if (w_gnt_v) begin
                if (w_gnt_id == r_owner) begin
                    if (r_hold_cnt < HOLD_LIMIT) begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end else begin
                    r_owner    <= w_gnt_id;
                    r_hold_cnt <= 4'd1;
                end
            end else begin
                r_hold_cnt <= 4'd0;
            end
            r_rd_pend <= w_gnt_rd;
            if (w_gnt_rd) begin
                r_rd_id <= w_gnt_id;
            end
        end
    end

    assign m0_waitrequest   = ~(w_gnt_v & ~w_gnt_id);
    assign m1_waitrequest   = ~(w_gnt_v & w_gnt_id);

    // With no grant the address/data lanes fall back to master 0 (don't-care).
    assign mem_address      = (w_gnt_v & w_gnt_id) ? m1_address    : m0_address;
    assign mem_byteenable   = (w_gnt_v & w_gnt_id) ? m1_byteenable : m0_byteenable;
    assign mem_writedata    = (w_gnt_v & w_gnt_id) ? m1_writedata  : m0_writedata;
    assign mem_chipselect   = w_gnt_v;
    assign mem_write        = w_gnt_v & (w_gnt_id ? m1_write : m0_write);
    assign mem_clken        = ~reset;

    assign m0_readdatavalid = r_rd_pend & ~r_rd_id;
    assign m1_readdatavalid = r_rd_pend & r_rd_id;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: behavioural RAM behind the arbiter, shadow memory
// reference and a readdatavalid scoreboard queue.
module tb_onchip_memory_arbiter;

  logic        clk;
  logic        reset;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];
  logic [31:0] shadow [0:16383];
  logic [31:0] ram [0:16383];
  logic [31:0] ram_q;
  logic        ram_loaded = 1'b0;

  onchip_memory_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [13:0] a);
    pat = {2'b01, a, 2'b10, ~a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    merge = o;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  // RAM model: address registered, data visible for the following cycle
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16384; i++) ram[i] <= pat(14'(i));
      ram_loaded <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_q <= ram[mem_address];
    end
  end
  assign mem_readdata = ram_q;

  // driver tasks
  task automatic drive(input int id, input logic rd, input logic wr, input logic [13:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 14'h0, 32'h0, 4'h0);
  endtask

  // One bus cycle: check grant outputs and the response scoreboard at negedge,
  // record expectations for the accepted transfer, return just after the next posedge.
  task automatic tick(input logic exp_v, input logic exp_id);
    logic [13:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    logic        ew, er;
    logic [32:0] e, got;
    @(negedge clk);
    ea = exp_id ? m1_address    : m0_address;
    ed = exp_id ? m1_writedata  : m0_writedata;
    eb = exp_id ? m1_byteenable : m0_byteenable;
    ew = exp_id ? m1_write      : m0_write;
    er = (exp_id ? m1_read : m0_read) & ~ew;

    n_tests++;
    if (m0_waitrequest !== !(exp_v && !exp_id)) begin
      n_fail++; $display("FAIL m0_waitrequest got=%b exp=%b", m0_waitrequest, !(exp_v && !exp_id));
    end
    n_tests++;
    if (m1_waitrequest !== !(exp_v && exp_id)) begin
      n_fail++; $display("FAIL m1_waitrequest got=%b exp=%b", m1_waitrequest, !(exp_v && exp_id));
    end
    n_tests++;
    if (mem_chipselect !== exp_v) begin
      n_fail++; $display("FAIL mem_chipselect got=%b exp=%b", mem_chipselect, exp_v);
    end
    n_tests++;
    if (mem_write !== (exp_v & ew)) begin
      n_fail++; $display("FAIL mem_write got=%b exp=%b", mem_write, exp_v & ew);
    end
    if (exp_v) begin
      n_tests++;
      if ({mem_address, mem_byteenable, mem_writedata} !== {ea, eb, ed}) begin
        n_fail++;
        $display("FAIL mem_lanes got=%h/%h/%h exp=%h/%h/%h",
                 mem_address, mem_byteenable, mem_writedata, ea, eb, ed);
      end
    end

    n_tests++;
    if (m0_readdatavalid && m1_readdatavalid) begin
      n_fail++; $display("FAIL rdv_both got=11 exp=one-hot");
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else if (m0_readdatavalid || m1_readdatavalid) begin
      got = {m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata};
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL rdv_unexpected got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++; $display("FAIL rdv_data got=id%0d:%h exp=id%0d:%h", got[32], got[31:0], e[32], e[31:0]);
        end
      end
      n_tests++;
      if (m0_readdata !== m1_readdata) begin
        n_fail++; $display("FAIL readdata_fanout got=%h exp=%h", m0_readdata, m1_readdata);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_fail++; $display("FAIL rdv_missing got=none exp=id%0d:%h", e[32], e[31:0]);
    end

    if (exp_v && er) exp_q.push_back({exp_id, shadow[ea]});
    if (exp_v && ew) shadow[ea] = merge(shadow[ea], ed, eb);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    drive(0, 1'b1, 1'b0, 14'h5, 32'h0, 4'hF);
    drive(1, 1'b0, 1'b1, 14'h6, 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      n_fail++; $display("FAIL rst_waitrequest got=%b%b exp=11", m0_waitrequest, m1_waitrequest);
    end
    n_tests++;
    if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mem_ctrl got=%b%b%b exp=000", mem_chipselect, mem_write, mem_clken);
    end
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_rdv got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid);
    end
    idle();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_chipselect, mem_clken, m0_waitrequest, m1_waitrequest} !== 4'b0111) begin
      n_fail++;
      $display("FAIL idle_after_rst got=%b%b%b%b exp=0111", mem_chipselect, mem_clken, m0_waitrequest, m1_waitrequest);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    drive(0, 1'b0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    tick(1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF);
    tick(1'b1, 1'b1);
    idle();
    tick(1'b0, 1'b0);
  endtask

  task automatic test_byte_lane();
    drive(0, 1'b0, 1'b1, 14'h0010, 32'h000000AA, 4'h1);
    tick(1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    tick(1'b0, 1'b0);
    n_tests++;
    if (shadow[14'h0010] !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL byte_lane_ref got=%h exp=deadbeaa", shadow[14'h0010]);
    end
  endtask

  task automatic test_contention();
    logic [13:0] a0, a1;
    logic        g;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    a0 = 14'h0100;
    a1 = 14'h0200;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b1, 1'b0, a0, 32'h0, 4'hF);
      drive(1, 1'b1, 1'b0, a1, 32'h0, 4'hF);
      g = (i >= 4 && i < 8);
      tick(1'b1, g);
      if (g) a1 = a1 + 14'd1;
      else   a0 = a0 + 14'd1;
    end
    idle();
    tick(1'b0, 1'b0);
  endtask

  task automatic test_rw_both();
    drive(0, 1'b1, 1'b1, 14'h3FFF, 32'h12345678, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    tick(1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 14'h3FFF, 32'h0, 4'hF);
    tick(1'b1, 1'b1);
    idle();
    tick(1'b0, 1'b0);
  endtask

  task automatic test_read_then_write();
    drive(0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    drive(1, 1'b0, 1'b1, 14'h0010, 32'hCAFEF00D, 4'hF);
    tick(1'b1, 1'b1);
    idle();
    drive(0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    drive(1, 1'b1, 1'b0, 14'h0030, 32'h0, 4'hF);
    tick(1'b1, 1'b1);
    reset = 1'b1;
    idle();
    exp_q.delete();
    @(negedge clk);
    n_tests++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_read_rdv got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid);
    end
    @(posedge clk); #1 reset = 1'b0;
    drive(0, 1'b1, 1'b0, 14'h0020, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 14'h0031, 32'h0, 4'hF);
    tick(1'b1, 1'b0);
    idle();
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    for (int i = 0; i < 16384; i++) shadow[i] = pat(14'(i));
    test_reset();
    test_write_read();
    test_byte_lane();
    test_contention();
    test_rw_both();
    test_read_then_write();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
